// File: rtl/bp_pkg.sv
// Branch predictor types and constants.
//   bht_ctr_t  : 2-bit saturating direction counter
//   BHT_INIT   : value every counter is swept to after reset (weakly not-taken)
//   BHT_MAX    : strongly-taken saturation value
//   bp_state_e : controller states
//   PC_STEP    : fall-through distance between sequential instructions
package bp_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_INIT = 2'b01;
  localparam bht_ctr_t BHT_MAX  = 2'b11;
  localparam int       PC_STEP  = 4;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

endpackage : bp_pkg

// File: rtl/cmp_pkg.sv
// Branch comparator definitions shared between the execute stage and the
// branch predictor.
//   cmp_op_e : compare operation attached to a resolved branch.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_NOP = 2'd0,
    CMP_BEQ = 2'd1,
    CMP_BLT = 2'd2,
    CMP_BLE = 2'd3
  } cmp_op_e;

endpackage : cmp_pkg

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
//   master : front end / execute stage (drives lookups and resolutions)
//   slave  : branch_predictor (returns prediction, redirect, statistics)
interface branch_predictor_if #(
  parameter int ADDR_WIDTH = 32
);
  import cmp_pkg::*;

  logic                  o_ready;
  logic                  i_pred_valid;
  logic [ADDR_WIDTH-1:0] i_pred_pc;
  logic                  o_pred_valid;
  logic                  o_pred_taken;
  logic                  i_res_valid;
  logic [ADDR_WIDTH-1:0] i_res_pc;
  cmp_op_e               i_res_op;
  logic                  i_res_taken;
  logic                  i_res_pred_taken;
  logic [ADDR_WIDTH-1:0] i_res_target;
  logic                  o_redirect;
  logic [ADDR_WIDTH-1:0] o_redirect_pc;
  logic [15:0]           o_mispredict_count;

  modport master (
    input  o_ready, o_pred_valid, o_pred_taken,
           o_redirect, o_redirect_pc, o_mispredict_count,
    output i_pred_valid, i_pred_pc,
           i_res_valid, i_res_pc, i_res_op, i_res_taken,
           i_res_pred_taken, i_res_target
  );

  modport slave (
    output o_ready, o_pred_valid, o_pred_taken,
           o_redirect, o_redirect_pc, o_mispredict_count,
    input  i_pred_valid, i_pred_pc,
           i_res_valid, i_res_pc, i_res_op, i_res_taken,
           i_res_pred_taken, i_res_target
  );

endinterface : branch_predictor_if

// File: rtl/branch_predictor_sat_ctr2.sv
// 2-bit saturating counter next-value logic (combinational).
//   ctr      : current counter value
//   taken    : observed branch outcome
//   ctr_next : counter moved one step toward the outcome, clamped at 0 / 3
module sat_ctr2
  import bp_pkg::*;
(
  input  bht_ctr_t ctr,
  input  logic     taken,
  output bht_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BHT_MAX) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

endmodule : sat_ctr2

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with execute-side resolution and redirect.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bp (slave)     : fetch lookup (i_pred_*), prediction (o_pred_*),
//                    resolution (i_res_*), redirect (o_redirect*),
//                    readiness and mispredict statistics
//
// state   | meaning
// --------+---------------------------------------------------------------
// BP_INIT | sweeping every counter to BHT_INIT, one entry per cycle
// BP_RUN  | table valid; lookups and resolutions accepted until reset
module branch_predictor
  import cmp_pkg::*;
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64
) (
  input logic               i_clk,
  input logic               i_rst_n,
  branch_predictor_if.slave bp
);

  localparam int IDX_WIDTH = $clog2(BHT_ENTRIES);

  typedef logic [IDX_WIDTH-1:0] idx_t;

  bp_state_e state_q, state_d;
  idx_t      init_idx_q;

  // Counter table: initialised by the INIT sweep, never by reset.
  bht_ctr_t  bht [BHT_ENTRIES];

  logic      bht_we;
  idx_t      bht_waddr;
  bht_ctr_t  bht_wdata;

  logic                  pred_valid_q;
  logic                  pred_taken_q;
  logic                  redirect_q;
  logic [ADDR_WIDTH-1:0] redirect_pc_q;
  logic [15:0]           mispredict_count_q;

  logic     run;
  idx_t     pred_idx;
  idx_t     res_idx;
  bht_ctr_t res_ctr;
  bht_ctr_t res_ctr_next;
  logic     do_res;
  logic     mispredict;

  assign run        = (state_q == BP_RUN);
  assign pred_idx   = bp.i_pred_pc[IDX_WIDTH+1:2];
  assign res_idx    = bp.i_res_pc[IDX_WIDTH+1:2];
  assign res_ctr    = bht[res_idx];
  assign do_res     = run && bp.i_res_valid && (bp.i_res_op != CMP_NOP);
  assign mispredict = bp.i_res_taken ^ bp.i_res_pred_taken;

  sat_ctr2 u_sat_ctr2 (
    .ctr      (res_ctr),
    .taken    (bp.i_res_taken),
    .ctr_next (res_ctr_next)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BP_INIT) init_idx_q <= init_idx_q + idx_t'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BP_INIT: if (init_idx_q == idx_t'(BHT_ENTRIES - 1)) state_d = BP_RUN;
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
  end

  // ---------------------------------------------------------------- table
  // Single write port: the INIT sweep and training never overlap.
  always_comb begin
    bht_we    = 1'b0;
    bht_waddr = '0;
    bht_wdata = BHT_INIT;
    if (state_q == BP_INIT) begin
      bht_we    = 1'b1;
      bht_waddr = init_idx_q;
      bht_wdata = BHT_INIT;
    end else if (do_res) begin
      bht_we    = 1'b1;
      bht_waddr = res_idx;
      bht_wdata = res_ctr_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (bht_we) bht[bht_waddr] <= bht_wdata;
  end

  // ---------------------------------------------------------------- outputs
  // The lookup samples the table before this edge's write lands, which gives
  // read-before-write when predict and resolve hit the same entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      redirect_q         <= 1'b0;
      redirect_pc_q      <= '0;
      mispredict_count_q <= '0;
    end else begin
      pred_valid_q <= run && bp.i_pred_valid;
      if (run && bp.i_pred_valid) pred_taken_q <= bht[pred_idx][1];

      redirect_q <= do_res && mispredict;
      if (do_res && mispredict) begin
        redirect_pc_q <= bp.i_res_taken ? bp.i_res_target
                                        : bp.i_res_pc + ADDR_WIDTH'(PC_STEP);
        if (mispredict_count_q != 16'hFFFF)
          mispredict_count_q <= mispredict_count_q + 16'd1;
      end
    end
  end

  assign bp.o_ready            = run;
  assign bp.o_pred_valid       = pred_valid_q;
  assign bp.o_pred_taken       = pred_taken_q;
  assign bp.o_redirect         = redirect_q;
  assign bp.o_redirect_pc      = redirect_pc_q;
  assign bp.o_mispredict_count = mispredict_count_q;

  // PC byte offset and bits above the index do not select a counter.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, bp.i_pred_pc[1:0], bp.i_res_pc[1:0]};

endmodule : branch_predictor
